// File: rtl/sorted_pair_serializer.sv
// Buffers sorted (lo,hi) pairs from the two-sorter in a small FIFO and emits them
// as a lo-then-hi word stream with valid/ready and a per-pair last flag.
module sorted_pair_serializer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] pair_lo,
  input  logic [WIDTH-1:0] pair_hi,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             clear_ovf,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, EMIT_LO, EMIT_HI} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   overflow_q, overflow_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [2*WIDTH-1:0]     mem_q [DEPTH];

  logic                   push, pop, drop;
  logic [2*WIDTH-1:0]     head;

  // Ready comes only from the registered count; a same-cycle pop does not free a slot.
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign drop     = in_valid && !in_ready;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    hi_d        = hi_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          out_data_d  = head[WIDTH-1:0];
          hi_d        = head[2*WIDTH-1:WIDTH];
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = EMIT_LO;
        end
      end
      EMIT_LO: begin
        if (out_ready) begin
          out_data_d = hi_q;
          out_last_d = 1'b1;
          state_d    = EMIT_HI;
        end
      end
      EMIT_HI: begin
        if (out_ready) begin
          if (count_q != '0) begin
            pop        = 1'b1;
            out_data_d = head[WIDTH-1:0];
            hi_d       = head[2*WIDTH-1:WIDTH];
            out_last_d = 1'b0;
            state_d    = EMIT_LO;
          end else begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_last_d  = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    // A drop in the same cycle as a clear keeps the flag set.
    overflow_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage only; its contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    if (push) mem_q[wr_ptr_q] <= {pair_hi, pair_lo};
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

endmodule
